currctrl_reset_pulse_pio: RTL and testbench
===========================================

// Module: currctrl_reset_pulse_pio
// PURPOSE
//  Multi-channel Avalon-MM output port for the current-control subsystem's reset and enable lines.
//  Parametrised successor to the 1-bit reset PIO: keeps direct-write and bit-set/bit-clear access,
//  and adds per-channel timed pulses that self-clear after a programmed cycle count.
//  Adds busy/done status and a done interrupt, so the CPU can pulse a reset without software timing.
// PARAMETERS
//  WIDTH          4     number of output channels, 1..32
//  CNT_W          16    pulse-length counter width, 1..32
//  RESET_VALUE    0     out_port value after reset (WIDTH bits)
//  DEFAULT_PULSE  16    PULSE_LEN register value after reset
// PORTS
//  clk         in   1      system clock
//  reset_n     in   1      asynchronous, active-low reset
//  address     in   3      word address
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe; wr = chipselect & ~write_n
//  writedata   in   32     write data; bits above WIDTH/CNT_W are ignored
//  readdata    out  32     read data, combinational from address, zero wait states, zero-extended
//  out_port    out  WIDTH  channel outputs
//  irq         out  1      |(DONE & IRQ_EN), registered
// BEHAVIOUR
//  Register map (address):
//    0 DATA   RW  write: out=wd; read: out
//    1 PULSE_LEN RW CNT_W
//    2 BUSY   RO  per-channel pulse active
//    3 DONE   RW1C sticky expiry flags
//    4 OUTSET WO  out |= wd
//    5 OUTCLR WO  out &= ~wd
//    6 PULSE  WO  start pulse on bits set in wd
//    7 IRQ_EN RW  WIDTH
//  Write-only addresses read 0.
//  Reset state: out=RESET_VALUE, PULSE_LEN=DEFAULT_PULSE, BUSY=0, DONE=0, IRQ_EN=0, irq=0.
//  Channel timing:
//    - Each channel i has a counter cnt[i] (CNT_W bits).
//    - PULSE write with wd[i]=1 in cycle T: out[i]=1 from T+1; cnt[i]=max(PULSE_LEN,1); BUSY[i]=1.
//    - While BUSY[i], cnt decrements each cycle. out[i] stays high for exactly max(PULSE_LEN,1) cycles,
//      then returns to 0.
//    - Expiry cycle (cnt==1): out[i]<=0, BUSY[i]<=0, DONE[i]<=1. irq follows one cycle after DONE.
//  Boundary conditions:
//    - PULSE write to a busy channel: reload the count (retrigger). No DONE for the aborted pulse;
//      out stays high with no glitch.
//    - PULSE write in the expiry cycle: retrigger wins; no DONE set.
//    - DATA/OUTSET/OUTCLR write touching a busy channel: cancels the pulse (BUSY=0, cnt=0, no DONE);
//      register value applies.
//      * Touching means wd[i]=1 for OUTSET/OUTCLR; always for DATA.
//    - DONE W1C in the same cycle as a new expiry on the same bit: set wins.
//    - PULSE_LEN write during active pulses: affects only subsequent triggers.
//    - Max length 2^CNT_W-1 cycles; no wrap-around. The counter stops at 0.
//    - Asynchronous reset mid-pulse: all state returns to reset values immediately. No DONE is recorded.
//    - Writes with chipselect=0 are ignored. Reads have no side effects.
// STRUCTURE
//  Shared package currctrl_pio_pkg:
//    - address constants ADDR_DATA..ADDR_IRQEN
//    - reg-width limits
//  Sub-module currctrl_pulse_chan, instantiated WIDTH times in a generate loop:
//    - inputs: trig, cancel, load value, direct-write enable/value
//    - owns cnt, out bit, busy
//    - emits a one-cycle expire pulse
//  Top level holds: bus decode, PULSE_LEN, DONE, IRQ_EN, readdata mux, irq register.
// TESTING
//  1. Reset with RESET_VALUE=4'b0101 -> out_port=0101, readdata@2=0, @1=16, irq=0.
//  2. OUTSET 4'b1000, then OUTCLR 4'b0001 -> DATA readback 1100.
//     DATA write 0x3 -> out_port=0011 next cycle.
//  3. PULSE_LEN=5, PULSE 4'b0010 at T -> out[1]=1 for T+1..T+5, 0 at T+6.
//     DONE=0010 at T+6. With IRQ_EN=0010, irq=1 at T+7.
//     W1C DONE -> irq=0.
//  4. PULSE_LEN=0 -> exactly one-cycle pulse.
//     PULSE_LEN=10, retrigger at cycle 7 of pulse -> high 17 cycles total, single DONE.
//  5. Mid-pulse OUTCLR on that bit -> out=0 next cycle, BUSY=0, DONE stays 0.
//     Mid-pulse reset_n low -> out=RESET_VALUE immediately.
//  6. Expiry coincident with DONE W1C on the same bit -> DONE remains 1.
//     Write with chipselect=0 -> no state change.

Source files
------------

// File: rtl/currctrl_pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : currctrl_pio_pkg
//  Description : Shared register map and width limits for the current-control
//                reset/enable PIO and its pulse channels.
//  Revision    : 1.0 - initial multi-channel pulse PIO
// ============================================================================
package currctrl_pio_pkg;

    // Avalon-MM bus geometry
    localparam int c_BUS_W  = 32;
    localparam int c_ADDR_W = 3;

    // Upper bounds for the WIDTH and CNT_W parameters
    localparam int c_MAX_WIDTH = 32;
    localparam int c_MAX_CNT_W = 32;

    // Register word addresses
    localparam logic [c_ADDR_W-1:0] c_ADDR_DATA      = 3'd0;
    localparam logic [c_ADDR_W-1:0] c_ADDR_PULSE_LEN = 3'd1;
    localparam logic [c_ADDR_W-1:0] c_ADDR_BUSY      = 3'd2;
    localparam logic [c_ADDR_W-1:0] c_ADDR_DONE      = 3'd3;
    localparam logic [c_ADDR_W-1:0] c_ADDR_OUTSET    = 3'd4;
    localparam logic [c_ADDR_W-1:0] c_ADDR_OUTCLR    = 3'd5;
    localparam logic [c_ADDR_W-1:0] c_ADDR_PULSE     = 3'd6;
    localparam logic [c_ADDR_W-1:0] c_ADDR_IRQEN     = 3'd7;

endpackage
`default_nettype wire

// File: rtl/currctrl_pulse_chan.sv
`default_nettype none
// ============================================================================
//  Module      : currctrl_pulse_chan
//  Description : One output channel: direct-write output bit plus a timed
//                self-clearing pulse with retrigger and cancel.
//  Revision    : 1.0 - initial multi-channel pulse PIO
// ============================================================================
module currctrl_pulse_chan
    import currctrl_pio_pkg::*;
#(
    parameter int   CNT_W     = 16,
    parameter logic RESET_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_trig,     // start / reload a pulse
    input  logic             i_cancel,   // abort an active pulse without DONE
    input  logic [CNT_W-1:0] i_load,     // pulse length, already forced >= 1
    input  logic             i_wr_en,    // direct write of the output bit
    input  logic             i_wr_val,
    output logic             o_out,
    output logic             o_busy,
    output logic             o_expire    // one-cycle, coincident with final high cycle
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             r_busy;
    logic             w_expire;

    // Expiry only when the last count is reached and no bus action overrides it
    always_comb begin
        w_expire = r_busy && (r_cnt == CNT_W'(1)) && !i_trig && !i_cancel && !i_wr_en;
    end

    // Channel state: trigger beats direct write, which beats the countdown
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_out  <= RESET_BIT;
            r_busy <= 1'b0;
        end else if (i_trig) begin
            r_cnt  <= i_load;
            r_out  <= 1'b1;
            r_busy <= 1'b1;
        end else if (i_wr_en || i_cancel) begin
            if (i_wr_en) begin
                r_out <= i_wr_val;
            end
            if (i_cancel) begin
                r_cnt  <= '0;
                r_busy <= 1'b0;
            end
        end else if (r_busy) begin
            if (r_cnt == CNT_W'(1)) begin
                r_cnt  <= '0;
                r_out  <= 1'b0;
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_out    = r_out;
    assign o_busy   = r_busy;
    assign o_expire = w_expire;

endmodule
`default_nettype wire

// File: rtl/currctrl_reset_pulse_pio.sv
`default_nettype none
// ============================================================================
//  Module      : currctrl_reset_pulse_pio
//  Description : Avalon-MM multi-channel output port with set/clear access,
//                timed self-clearing pulses, busy/done status and done irq.
//  Revision    : 1.0 - initial multi-channel pulse PIO
// ============================================================================
module currctrl_reset_pulse_pio
    import currctrl_pio_pkg::*;
#(
    parameter int               WIDTH         = 4,    // 1..c_MAX_WIDTH
    parameter int               CNT_W         = 16,   // 1..c_MAX_CNT_W
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
    parameter int               DEFAULT_PULSE = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [c_ADDR_W-1:0] address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [c_BUS_W-1:0]  writedata,
    output logic [c_BUS_W-1:0]  readdata,
    output logic [WIDTH-1:0]    out_port,
    output logic                irq
);

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_trig;
    logic [WIDTH-1:0] w_dw_en;
    logic [WIDTH-1:0] w_dw_val;
    logic [WIDTH-1:0] w_out;
    logic [WIDTH-1:0] w_busy;
    logic [WIDTH-1:0] w_expire;
    logic [CNT_W-1:0] w_load;
    logic             w_unused;

    logic [CNT_W-1:0] r_pulse_len;
    logic [WIDTH-1:0] r_done;
    logic [WIDTH-1:0] r_irq_en;
    logic             r_irq;

    assign w_wr     = chipselect & ~write_n;
    assign w_wd     = writedata[WIDTH-1:0];
    assign w_unused = ^writedata;

    // A programmed length of zero still yields a single-cycle pulse
    always_comb begin
        w_load = (r_pulse_len == '0) ? CNT_W'(1) : r_pulse_len;
    end

    // Per-channel trigger and direct-write decode; any direct write cancels
    always_comb begin
        w_trig   = '0;
        w_dw_en  = '0;
        w_dw_val = '0;
        if (w_wr) begin
            case (address)
                c_ADDR_DATA: begin
                    w_dw_en  = '1;
                    w_dw_val = w_wd;
                end
                c_ADDR_OUTSET: begin
                    w_dw_en  = w_wd;
                    w_dw_val = '1;
                end
                c_ADDR_OUTCLR: begin
                    w_dw_en  = w_wd;
                    w_dw_val = '0;
                end
                c_ADDR_PULSE: begin
                    w_trig = w_wd;
                end
                default: begin
                    w_trig = '0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            currctrl_pulse_chan #(
                .CNT_W     (CNT_W),
                .RESET_BIT (RESET_VALUE[gi])
            ) u_chan (
                .clk      (clk),
                .reset_n  (reset_n),
                .i_trig   (w_trig[gi]),
                .i_cancel (w_dw_en[gi]),
                .i_load   (w_load),
                .i_wr_en  (w_dw_en[gi]),
                .i_wr_val (w_dw_val[gi]),
                .o_out    (w_out[gi]),
                .o_busy   (w_busy[gi]),
                .o_expire (w_expire[gi])
            );
        end
    endgenerate

    // Control registers; a new expiry wins over a same-cycle W1C of DONE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pulse_len <= CNT_W'(DEFAULT_PULSE);
            r_done      <= '0;
            r_irq_en    <= '0;
        end else begin
            if (w_wr && address == c_ADDR_PULSE_LEN) begin
                r_pulse_len <= writedata[CNT_W-1:0];
            end
            if (w_wr && address == c_ADDR_IRQEN) begin
                r_irq_en <= w_wd;
            end
            if (w_wr && address == c_ADDR_DONE) begin
                r_done <= (r_done & ~w_wd) | w_expire;
            end else begin
                r_done <= r_done | w_expire;
            end
        end
    end

    // Interrupt is registered, so it trails DONE by one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_done & r_irq_en);
        end
    end

    // Zero-wait-state read mux, zero-extended; write-only words read 0
    always_comb begin
        readdata = '0;
        case (address)
            c_ADDR_DATA:      readdata[WIDTH-1:0] = w_out;
            c_ADDR_PULSE_LEN: readdata[CNT_W-1:0] = r_pulse_len;
            c_ADDR_BUSY:      readdata[WIDTH-1:0] = w_busy;
            c_ADDR_DONE:      readdata[WIDTH-1:0] = r_done;
            c_ADDR_IRQEN:     readdata[WIDTH-1:0] = r_irq_en;
            default:          readdata = '0;
        endcase
    end

    assign out_port = w_out;
    assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_currctrl_reset_pulse_pio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_currctrl_reset_pulse_pio
//  Description : Directed self-checking bench for currctrl_reset_pulse_pio.
//  Revision    : 1.0 - initial
// ============================================================================
module tb_currctrl_reset_pulse_pio;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  out_port;
    logic        irq;

    int checks;
    int errors;

    currctrl_reset_pulse_pio #(
        .WIDTH         (4),
        .CNT_W         (16),
        .RESET_VALUE   (4'b0101),
        .DEFAULT_PULSE (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge: write occupies this cycle, returns at next negedge
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    // Combinational read, no clock advance
    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_port !== 4'b0101) begin errors++; $display("FAIL reset_out actual=%b expected=0101", out_port); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_port !== 4'b0101) begin errors++; $display("FAIL reset_out_after actual=%b expected=0101", out_port); end
        bus_read(3'd2, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL reset_busy actual=%h expected=0", rd); end
        bus_read(3'd1, rd);
        checks++;
        if (rd !== 32'd16) begin errors++; $display("FAIL reset_pulse_len actual=%h expected=10", rd); end
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL reset_done actual=%h expected=0", rd); end
        bus_read(3'd7, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL reset_irqen actual=%h expected=0", rd); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq actual=%b expected=0", irq); end
    endtask

    task automatic test_set_clr_data();
        logic [31:0] rd;
        bus_write(3'd4, 32'h8);
        bus_write(3'd5, 32'h1);
        bus_read(3'd0, rd);
        checks++;
        if (rd !== 32'hC) begin errors++; $display("FAIL setclr_readback actual=%h expected=c", rd); end
        bus_read(3'd6, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL wo_reads_zero actual=%h expected=0", rd); end
        bus_write(3'd0, 32'h3);
        checks++;
        if (out_port !== 4'b0011) begin errors++; $display("FAIL data_write actual=%b expected=0011", out_port); end
    endtask

    task automatic test_pulse_irq();
        logic [31:0] rd;
        bus_write(3'd0, 32'h0);
        bus_write(3'd1, 32'd5);
        bus_write(3'd7, 32'h2);
        bus_write(3'd6, 32'h2);          // cycle T; now at T+1
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (out_port !== 4'b0010) begin errors++; $display("FAIL pulse_high_T+%0d actual=%b expected=0010", k, out_port); end
            if (k == 3) begin
                bus_read(3'd2, rd);
                checks++;
                if (rd !== 32'h2) begin errors++; $display("FAIL pulse_busy actual=%h expected=2", rd); end
            end
            @(negedge clk);
        end
        checks++;
        if (out_port !== 4'b0000) begin errors++; $display("FAIL pulse_low_T+6 actual=%b expected=0000", out_port); end
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL pulse_done actual=%h expected=2", rd); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_T+6 actual=%b expected=0", irq); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_T+7 actual=%b expected=1", irq); end
        bus_write(3'd3, 32'h2);
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared actual=%b expected=0", irq); end
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL done_w1c actual=%h expected=0", rd); end
    endtask

    task automatic test_len_zero_retrigger();
        logic [31:0] rd;
        int high;
        int guard;
        bus_write(3'd1, 32'd0);
        bus_write(3'd6, 32'h1);
        checks++;
        if (out_port !== 4'b0001) begin errors++; $display("FAIL len0_high actual=%b expected=0001", out_port); end
        @(negedge clk);
        checks++;
        if (out_port !== 4'b0000) begin errors++; $display("FAIL len0_low actual=%b expected=0000", out_port); end
        bus_write(3'd3, 32'hF);
        bus_write(3'd1, 32'd10);
        bus_write(3'd6, 32'h4);          // cycle T; now at T+1
        high = 0;
        for (int k = 1; k <= 6; k++) begin
            if (out_port[2] === 1'b1) high++;
            @(negedge clk);
        end
        if (out_port[2] === 1'b1) high++; // T+7
        bus_write(3'd6, 32'h4);          // retrigger in T+7; now at T+8
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL retrig_no_done actual=%h expected=0", rd); end
        guard = 0;
        while (out_port[2] === 1'b1 && guard < 40) begin
            high++;
            guard++;
            @(negedge clk);
        end
        checks++;
        if (high != 17) begin errors++; $display("FAIL retrig_high_cycles actual=%0d expected=17", high); end
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL retrig_done actual=%h expected=4", rd); end
        bus_write(3'd3, 32'hF);
    endtask

    task automatic test_cancel_and_async_reset();
        logic [31:0] rd;
        bus_write(3'd6, 32'h8);          // PULSE_LEN still 10
        repeat (2) @(negedge clk);
        bus_write(3'd5, 32'h8);
        checks++;
        if (out_port !== 4'b0000) begin errors++; $display("FAIL cancel_out actual=%b expected=0000", out_port); end
        bus_read(3'd2, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL cancel_busy actual=%h expected=0", rd); end
        repeat (15) @(negedge clk);
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL cancel_done actual=%h expected=0", rd); end
        bus_write(3'd6, 32'h2);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_port !== 4'b0101) begin errors++; $display("FAIL async_reset_out actual=%b expected=0101", out_port); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL async_reset_done actual=%h expected=0", rd); end
        bus_read(3'd1, rd);
        checks++;
        if (rd !== 32'd16) begin errors++; $display("FAIL async_reset_len actual=%h expected=10", rd); end
        checks++;
        if (out_port !== 4'b0101) begin errors++; $display("FAIL async_reset_hold actual=%b expected=0101", out_port); end
    endtask

    task automatic test_expiry_vs_w1c_and_cs();
        logic [31:0] rd;
        bus_write(3'd0, 32'h0);
        bus_write(3'd1, 32'd3);
        bus_write(3'd6, 32'h1);          // cycle T; now at T+1
        repeat (2) @(negedge clk);       // now at T+3 (expiry cycle)
        bus_write(3'd3, 32'h1);
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL expiry_beats_w1c actual=%h expected=1", rd); end
        checks++;
        if (out_port !== 4'b0000) begin errors++; $display("FAIL expiry_out actual=%b expected=0000", out_port); end
        address    = 3'd0;
        writedata  = 32'hF;
        chipselect = 1'b0;
        write_n    = 1'b0;
        @(negedge clk);
        address    = 3'd6;
        @(negedge clk);
        write_n    = 1'b1;
        checks++;
        if (out_port !== 4'b0000) begin errors++; $display("FAIL cs0_no_write actual=%b expected=0000", out_port); end
        bus_read(3'd2, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL cs0_no_pulse actual=%h expected=0", rd); end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        @(negedge clk);
        test_reset();
        test_set_clr_data();
        test_pulse_irq();
        test_len_zero_retrigger();
        test_cancel_and_async_reset();
        test_expiry_vs_w1c_and_cs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
